branch_redirect_ctrl: RTL and testbench

//  Sequences every frontend redirect in the core. Sources are the branch unit's

---
 rtl/branch_redirect_ctrl.sv | 132 +++++++++++++
 tb/tb_branch_redirect_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/branch_redirect_ctrl.sv
// Frontend redirect sequencer: boot vector, branch mispredicts and traps -> flush window -> fetch handshake.
// Optional perf counters enabled by defining BRANCH_REDIRECT_PERF_EN.
module branch_redirect_ctrl #(
  parameter int unsigned              AWIDTH       = 30,
  parameter int unsigned              FLUSH_CYCLES = 2,
  parameter logic [AWIDTH-1:0]        RESET_VEC    = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              br_jump,
  input  logic [AWIDTH-1:0] br_jump_vec,
  input  logic              trap_req,
  input  logic [AWIDTH-1:0] trap_vec,
  input  logic              fetch_ready,
  output logic              redir_valid,
  output logic [AWIDTH-1:0] redir_vec,
  output logic              flush,
  output logic              issue_hold,
  output logic [31:0]       cnt_redirects,
  output logic [31:0]       cnt_hold
);

  localparam int unsigned CW = (FLUSH_CYCLES < 1) ? 1 : $clog2(FLUSH_CYCLES + 1);
  localparam logic [CW-1:0] CNT_RELOAD = CW'((FLUSH_CYCLES < 1) ? 0 : FLUSH_CYCLES - 1);

  if (FLUSH_CYCLES < 1) begin : g_bad_flush_cycles
    $error("branch_redirect_ctrl: FLUSH_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_IDLE,
    ST_FLUSH,
    ST_REDIRECT
  } state_e;

  state_e            state_q;
  logic              redir_valid_q;
  logic [AWIDTH-1:0] redir_vec_q;
  logic              flush_q;
  logic [CW-1:0]     cnt_q;

  // Redirect sequencer; a trap always wins and restarts the flush window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_BOOT;
      redir_valid_q <= 1'b0;
      redir_vec_q   <= RESET_VEC;
      flush_q       <= 1'b0;
      cnt_q         <= '0;
    end else begin
      case (state_q)
        ST_BOOT: begin
          redir_valid_q <= 1'b1;
          redir_vec_q   <= RESET_VEC;
          state_q       <= ST_REDIRECT;
        end
        ST_IDLE: begin
          if (trap_req || br_jump) begin
            redir_vec_q <= trap_req ? trap_vec : br_jump_vec;
            flush_q     <= 1'b1;
            cnt_q       <= CNT_RELOAD;
            state_q     <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (trap_req) begin
            redir_vec_q <= trap_vec;
            cnt_q       <= CNT_RELOAD;
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
          end else begin
            flush_q       <= 1'b0;
            redir_valid_q <= 1'b1;
            state_q       <= ST_REDIRECT;
          end
        end
        ST_REDIRECT: begin
          // With a same-cycle handshake the current redirect retires, then the trap starts fresh.
          if (trap_req) begin
            redir_valid_q <= 1'b0;
            redir_vec_q   <= trap_vec;
            flush_q       <= 1'b1;
            cnt_q         <= CNT_RELOAD;
            state_q       <= ST_FLUSH;
          end else if (fetch_ready) begin
            redir_valid_q <= 1'b0;
            state_q       <= ST_IDLE;
          end
        end
        default: state_q <= ST_BOOT;
      endcase
    end
  end

  assign redir_valid = redir_valid_q;
  assign redir_vec   = redir_vec_q;
  assign flush       = flush_q;
  assign issue_hold  = (state_q != ST_IDLE);

`ifdef BRANCH_REDIRECT_PERF_EN
  logic [31:0] cnt_redirects_q;
  logic [31:0] cnt_hold_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_redirects_q <= '0;
      cnt_hold_q      <= '0;
    end else begin
      if (redir_valid_q && fetch_ready) cnt_redirects_q <= cnt_redirects_q + 32'd1;
      if (issue_hold)                   cnt_hold_q      <= cnt_hold_q + 32'd1;
    end
  end

  assign cnt_redirects = cnt_redirects_q;
  assign cnt_hold      = cnt_hold_q;
`else
  assign cnt_redirects = 32'h0;
  assign cnt_hold      = 32'h0;
`endif

`ifndef SYNTHESIS
  // The branch unit must never request a redirect while issue is held.
  always @(posedge clk) begin
    if (!reset) begin
      assert (!(br_jump && issue_hold))
        else $error("branch_redirect_ctrl: br_jump asserted while issue_hold=1");
    end
  end
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed table-driven bench for branch_redirect_ctrl plus reset/boot corner sequences.
module tb_branch_redirect_ctrl;

  localparam int unsigned AW = 30;
  localparam int NROWS = 33;

  logic          clk = 1'b0;
  logic          reset;
  logic          br_jump;
  logic [AW-1:0] br_jump_vec;
  logic          trap_req;
  logic [AW-1:0] trap_vec;
  logic          fetch_ready;
  logic          redir_valid;
  logic [AW-1:0] redir_vec;
  logic          flush;
  logic          issue_hold;
  logic [31:0]   cnt_redirects;
  logic [31:0]   cnt_hold;

  int total = 0;
  int bad   = 0;

`ifdef BRANCH_REDIRECT_PERF_EN
  localparam int PERF = 1;
`else
  localparam int PERF = 0;
`endif

  always #5 clk = ~clk;

  branch_redirect_ctrl #(
    .AWIDTH      (AW),
    .FLUSH_CYCLES(2),
    .RESET_VEC   ('0)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .br_jump      (br_jump),
    .br_jump_vec  (br_jump_vec),
    .trap_req     (trap_req),
    .trap_vec     (trap_vec),
    .fetch_ready  (fetch_ready),
    .redir_valid  (redir_valid),
    .redir_vec    (redir_vec),
    .flush        (flush),
    .issue_hold   (issue_hold),
    .cnt_redirects(cnt_redirects),
    .cnt_hold     (cnt_hold)
  );

  // Expected outputs in the current cycle, then the inputs driven during that cycle.
  typedef struct {
    logic          ev;
    logic [AW-1:0] evec;
    logic          ef;
    logic          eh;
    logic          br;
    logic [AW-1:0] bvec;
    logic          trap;
    logic [AW-1:0] tvec;
    logic          rdy;
  } row_t;

  row_t tbl[NROWS];

  function automatic row_t mk(logic ev, int evec, logic ef, logic eh,
                              logic br, int bvec, logic trap, int tvec, logic rdy);
    row_t r;
    r.ev = ev;  r.evec = AW'(evec); r.ef = ef;   r.eh = eh;
    r.br = br;  r.bvec = AW'(bvec); r.trap = trap; r.tvec = AW'(tvec); r.rdy = rdy;
    return r;
  endfunction

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  task automatic drive(logic br, int bvec, logic trap, int tvec, logic rdy);
    br_jump     = br;
    br_jump_vec = AW'(bvec);
    trap_req    = trap;
    trap_vec    = AW'(tvec);
    fetch_ready = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_r;
    int exp_h;

    //           ev  evec   ef  eh   br bvec   trap tvec   rdy
    tbl[0]  = mk(0, 'h000, 0, 1,   0, 0,     0, 0,     1); // BOOT
    tbl[1]  = mk(1, 'h000, 0, 1,   0, 0,     0, 0,     1); // boot redirect accepted
    tbl[2]  = mk(0, 'h000, 0, 0,   1, 'h100, 0, 0,     1); // branch at N
    tbl[3]  = mk(0, 'h100, 1, 1,   0, 0,     0, 0,     1);
    tbl[4]  = mk(0, 'h100, 1, 1,   0, 0,     0, 0,     1);
    tbl[5]  = mk(1, 'h100, 0, 1,   0, 0,     0, 0,     1); // N+3 redirect
    tbl[6]  = mk(0, 'h100, 0, 0,   1, 'h100, 1, 'h040, 1); // trap beats branch
    tbl[7]  = mk(0, 'h040, 1, 1,   0, 0,     0, 0,     1);
    tbl[8]  = mk(0, 'h040, 1, 1,   0, 0,     0, 0,     1);
    tbl[9]  = mk(1, 'h040, 0, 1,   0, 0,     0, 0,     1);
    tbl[10] = mk(0, 'h040, 0, 0,   0, 0,     0, 0,     0); // idle, nothing requested
    tbl[11] = mk(0, 'h040, 0, 0,   1, 'h100, 0, 0,     0);
    tbl[12] = mk(0, 'h100, 1, 1,   0, 0,     0, 0,     0);
    tbl[13] = mk(0, 'h100, 1, 1,   0, 0,     0, 0,     0);
    tbl[14] = mk(1, 'h100, 0, 1,   0, 0,     0, 0,     0); // backpressure x5
    tbl[15] = mk(1, 'h100, 0, 1,   0, 0,     0, 0,     0);
    tbl[16] = mk(1, 'h100, 0, 1,   0, 0,     0, 0,     0);
    tbl[17] = mk(1, 'h100, 0, 1,   0, 0,     0, 0,     0);
    tbl[18] = mk(1, 'h100, 0, 1,   0, 0,     0, 0,     0);
    tbl[19] = mk(1, 'h100, 0, 1,   0, 0,     0, 0,     1); // ready rises -> handshake
    tbl[20] = mk(0, 'h100, 0, 0,   1, 'h200, 0, 0,     0);
    tbl[21] = mk(0, 'h200, 1, 1,   0, 0,     0, 0,     0);
    tbl[22] = mk(0, 'h200, 1, 1,   0, 0,     0, 0,     0);
    tbl[23] = mk(1, 'h200, 0, 1,   0, 0,     1, 'h040, 0); // late trap in REDIRECT
    tbl[24] = mk(0, 'h040, 1, 1,   0, 0,     0, 0,     0);
    tbl[25] = mk(0, 'h040, 1, 1,   0, 0,     1, 'h080, 0); // trap in FLUSH extends window
    tbl[26] = mk(0, 'h080, 1, 1,   0, 0,     0, 0,     0);
    tbl[27] = mk(0, 'h080, 1, 1,   0, 0,     0, 0,     0);
    tbl[28] = mk(1, 'h080, 0, 1,   0, 0,     1, 'h300, 1); // trap + handshake together
    tbl[29] = mk(0, 'h300, 1, 1,   0, 0,     0, 0,     0);
    tbl[30] = mk(0, 'h300, 1, 1,   0, 0,     0, 0,     0);
    tbl[31] = mk(1, 'h300, 0, 1,   0, 0,     0, 0,     1);
    tbl[32] = mk(0, 'h300, 0, 0,   0, 0,     0, 0,     0);

    reset = 1'b1;
    drive(0, 0, 0, 0, 0);
    repeat (3) tick();
    chk("rst valid", 32'(redir_valid), 32'd0);
    chk("rst vec",   32'(redir_vec),   32'd0);
    chk("rst flush", 32'(flush),       32'd0);
    chk("rst hold",  32'(issue_hold),  32'd1);
    chk("rst cnt_redirects", cnt_redirects, 32'd0);
    chk("rst cnt_hold",      cnt_hold,      32'd0);
    reset = 1'b0;

    exp_r = 0;
    exp_h = 0;
    for (int i = 0; i < NROWS; i++) begin
      chk($sformatf("row%0d valid", i), 32'(redir_valid), 32'(tbl[i].ev));
      chk($sformatf("row%0d vec", i),   32'(redir_vec),   32'(tbl[i].evec));
      chk($sformatf("row%0d flush", i), 32'(flush),       32'(tbl[i].ef));
      chk($sformatf("row%0d hold", i),  32'(issue_hold),  32'(tbl[i].eh));
      chk($sformatf("row%0d cnt_redirects", i), cnt_redirects, 32'(exp_r * PERF));
      chk($sformatf("row%0d cnt_hold", i),      cnt_hold,      32'(exp_h * PERF));
      if (tbl[i].ev && tbl[i].rdy) exp_r++;
      if (tbl[i].eh) exp_h++;
      drive(tbl[i].br, int'(tbl[i].bvec), tbl[i].trap, int'(tbl[i].tvec), tbl[i].rdy);
      tick();
    end

    // Reset mid-flush drops the pending branch target immediately.
    drive(1, 'h123, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    chk("midop flush before reset", 32'(flush),     32'd1);
    chk("midop vec before reset",   32'(redir_vec), 32'h123);
    #2 reset = 1'b1;
    #1;
    chk("midop rst valid", 32'(redir_valid), 32'd0);
    chk("midop rst vec",   32'(redir_vec),   32'd0);
    chk("midop rst flush", 32'(flush),       32'd0);
    chk("midop rst hold",  32'(issue_hold),  32'd1);
    chk("midop rst cnt_redirects", cnt_redirects, 32'd0);

    // Trap held through BOOT is ignored; the boot redirect goes out first.
    tick();
    drive(0, 0, 1, 'h55, 0);
    reset = 1'b0;
    tick();
    drive(0, 0, 0, 0, 1);
    chk("boot-trap valid", 32'(redir_valid), 32'd1);
    chk("boot-trap vec",   32'(redir_vec),   32'd0);
    chk("boot-trap flush", 32'(flush),       32'd0);
    tick();
    drive(0, 0, 0, 0, 0);
    chk("boot-trap idle hold",  32'(issue_hold),  32'd0);
    chk("boot-trap idle valid", 32'(redir_valid), 32'd0);
    chk("boot-trap idle vec",   32'(redir_vec),   32'd0);
    chk("boot-trap cnt_redirects", cnt_redirects, 32'(PERF));
    chk("boot-trap cnt_hold",      cnt_hold,      32'(2 * PERF));
    tick();
    chk("boot-trap stays idle", 32'(issue_hold), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
